// File: rtl/scan_counter_pkg.sv
// Shared Connect6 constants and scan-state encodings.
// Imported by the scan counter and its wrap counters.
package connect6_pkg;

  localparam int BOARD_ROWS = 19;
  localparam int BOARD_COLS = 19;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  localparam logic ROW_MAJOR = 1'b0;
  localparam logic COL_MAJOR = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_counter_if.sv
// Coordinate stream from the scan counter to the
// board-evaluation pipeline (valid/ready).
interface scan_counter_if #(
  parameter int RW = 5,
  parameter int CW = 5
);

  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  modport master (
    output out_valid,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/scan_counter_wrap.sv
// Index counter 0..MAX that wraps to 0 when
// incremented at MAX.
module wrap_counter #(
  parameter int MAX = 18,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         at_max
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  assign at_max = (value_q == W'(MAX));
  assign value  = value_q;

  // Next index: hold, step, or wrap at MAX.
  always_comb begin
    value_d = value_q;
    if (inc) begin
      value_d = at_max ? '0 : value_q + 1'b1;
    end
  end

  // Index register; reset and abort both return to 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/scan_counter.sv
// Two-dimensional board scan counter emitting every
// coordinate once, row- or column-major, on a stream.
module scan_counter
  import connect6_pkg::*;
#(
  parameter  int ROWS = BOARD_ROWS,
  parameter  int COLS = BOARD_COLS,
  localparam int RW   = idx_w(ROWS),
  localparam int CW   = idx_w(COLS),
  localparam int NW   = $clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          start,
  input  logic          col_major,
  scan_counter_if.master out,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] count
);

  scan_state_e   state_q;
  logic          mode_q;
  logic [NW-1:0] count_q;
  logic          done_q;
  logic          busy_q;

  logic          xfer;
  logic          row_inc;
  logic          col_inc;
  logic          row_max;
  logic          col_max;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  assign out.out_valid = (state_q == SCAN);
  assign out.out_row   = row;
  assign out.out_col   = col;
  assign out.out_last  = out.out_valid
                       && row_max && col_max;

  assign xfer = out.out_valid && out.out_ready;

  // The inner counter steps on every transfer; the
  // outer one only when the inner wraps.
  always_comb begin
    row_inc = xfer && col_max;
    col_inc = xfer;
    if (mode_q == COL_MAJOR) begin
      row_inc = xfer;
      col_inc = xfer && row_max;
    end
  end

  wrap_counter #(.MAX(ROWS-1), .W(RW)) u_row (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (row_inc),
    .value  (row),
    .at_max (row_max)
  );

  wrap_counter #(.MAX(COLS-1), .W(CW)) u_col (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (col_inc),
    .value  (col),
    .at_max (col_max)
  );

  // Scan FSM with registered busy/done/count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= ROW_MAJOR;
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            mode_q  <= col_major;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (xfer) begin
            count_q <= count_q + 1'b1;
          end
          if (xfer && out.out_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_scan_counter.sv
// Directed bench for scan_counter: full 19x19 scans,
// backpressure, abort, reset and a 1x1 board.
module tb_scan_counter;

  logic clk = 1'b0;
  logic rst, clr, start, col_major;
  logic busy, done;
  logic [8:0] count;

  logic s_clr, s_start, s_cm;
  logic s_busy, s_done;
  logic [0:0] s_count;

  int n_chk  = 0;
  int n_fail = 0;

  scan_counter_if #(.RW(5), .CW(5)) bus ();
  scan_counter_if #(.RW(1), .CW(1)) sbus ();

  always #5 clk = ~clk;

  scan_counter dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .start     (start),
    .col_major (col_major),
    .out       (bus),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  scan_counter #(.ROWS(1), .COLS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .clr       (s_clr),
    .start     (s_start),
    .col_major (s_cm),
    .out       (sbus),
    .busy      (s_busy),
    .done      (s_done),
    .count     (s_count)
  );

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full scan: cm = column-major, tog = flip col_major
  // mid-scan, bp = 1,0,0,1 ready pattern plus a stray
  // start during the scan.
  task automatic full_scan(input bit cm,
                           input bit tog,
                           input bit bp);
    int k;
    int cyc;
    logic [4:0] er, ec;
    logic el;
    col_major = cm;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("first_valid", int'(bus.out_valid), 1);
    k   = 0;
    cyc = 0;
    while (k < 361 && cyc < 3000) begin
      bus.out_ready = bp ? (cyc % 4 == 0 ||
                            cyc % 4 == 3) : 1'b1;
      if (tog && cyc == 100) col_major = ~cm;
      start = (bp && cyc == 37);
      er = cm ? 5'(k % 19) : 5'(k / 19);
      ec = cm ? 5'(k / 19) : 5'(k % 19);
      el = (k == 360);
      chk("beat", int'({bus.out_valid, bus.out_row,
                        bus.out_col, bus.out_last, done}),
          int'({1'b1, er, ec, el, 1'b0}));
      step();
      if (bus.out_ready) k++;
      cyc++;
    end
    start = 1'b0;
    chk("beats", k, 361);
    chk("done_pulse", int'(done), 1);
    chk("end_valid", int'(bus.out_valid), 0);
    chk("end_busy", int'(busy), 0);
    chk("end_count", int'(count), 361);
    chk("end_coord", int'({bus.out_row, bus.out_col}), 0);
    step();
    chk("done_once", int'(done), 0);
    chk("count_hold", int'(count), 361);
    col_major     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; start = 1'b0;
    col_major = 1'b0;
    bus.out_ready = 1'b1;
    s_clr = 1'b0; s_start = 1'b0; s_cm = 1'b0;
    sbus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_outs", int'({busy, done, bus.out_last}), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_coord", int'({bus.out_row, bus.out_col}), 0);
    step();
    chk("idle_hold", int'(bus.out_valid), 0);

    full_scan(1'b0, 1'b0, 1'b0);
    full_scan(1'b1, 1'b1, 1'b0);
    full_scan(1'b0, 1'b0, 1'b1);

    // Abort after 50 beats.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 50; i++) step();
    chk("pre_clr_coord",
        int'({bus.out_row, bus.out_col}),
        int'({5'd2, 5'd12}));
    chk("pre_clr_count", int'(count), 50);
    clr = 1'b1;
    start = 1'b1;
    step();
    clr = 1'b0;
    start = 1'b0;
    chk("clr_valid", int'(bus.out_valid), 0);
    chk("clr_coord", int'({bus.out_row, bus.out_col}), 0);
    chk("clr_count", int'(count), 0);
    chk("clr_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      chk("clr_no_done", int'(done), 0);
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart", int'({bus.out_valid, bus.out_row,
                         bus.out_col}), 1 << 10);
    chk("restart_count", int'(count), 0);

    // Reset with start mid-scan.
    for (int i = 0; i < 5; i++) step();
    chk("mid_coord", int'(bus.out_col), 5);
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("rst2_valid", int'(bus.out_valid), 0);
    chk("rst2_outs", int'({busy, done, bus.out_last}), 0);
    chk("rst2_count", int'(count), 0);
    chk("rst2_coord", int'({bus.out_row, bus.out_col}), 0);
    step();
    chk("rst2_idle", int'(bus.out_valid), 0);

    // 1x1 board.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("b1_beat", int'({sbus.out_valid, sbus.out_last,
                        sbus.out_row, sbus.out_col,
                        s_busy}), 5'b11001);
    step();
    chk("b1_done", int'({s_done, sbus.out_valid}), 2);
    chk("b1_count", int'(s_count), 1);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("b1_again", int'({sbus.out_valid, sbus.out_last,
                         s_done}), 3'b110);
    chk("b1_count0", int'(s_count), 0);
    step();
    chk("b1_done2", int'(s_done), 1);
    step();
    chk("b1_done_end", int'(s_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
